washer_panel_ctrl: RTL and testbench

Front-panel initiator for the washer program controller. It debounces the raw user buttons and switches, and keeps the power and program-selection state. It issues the single-cycle start request and drives the power, program_selection, start, doorclosed and soap inputs of the controller. It also consumes the controller's status outputs (program_done, soap_warning, timer_display) to drive the panel display, LEDs and door lock.

---
 rtl/washer_pkg.sv | 34 +++
 rtl/washer_panel_ctrl_if.sv | 21 ++
 rtl/panel_debounce.sv | 49 ++++
 rtl/washer_panel_ctrl.sv | 171 +++++++++++++++++
 tb/tb_washer_panel_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/washer_pkg.sv
// Shared program codes, panel state encodings and default timing for the washer front panel.
package washer_pkg;

  typedef enum logic [2:0] {
    COLD_WASH   = 3'd0,
    HOT_WASH    = 3'd1,
    RINSING_DRY = 3'd2,
    ONLY_DRY    = 3'd3,
    WARM_WASH   = 3'd4
  } program_e;

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 4;
  localparam int unsigned DEF_NUM_PROGRAMS     = 5;
  localparam int unsigned DEF_DONE_HOLD_CYCLES = 16;
  localparam int unsigned CHILD_LOCK_HOLD      = 64;

  // Bit positions of the raw inputs inside the conditioned input vectors.
  localparam int unsigned BTN_POWER = 0;
  localparam int unsigned BTN_SEL   = 1;
  localparam int unsigned BTN_START = 2;
  localparam int unsigned BTN_DOOR  = 3;
  localparam int unsigned BTN_SOAP  = 4;

  function automatic logic [2:0] next_program(input logic [2:0] cur, input int unsigned num);
    if ({29'd0, cur} + 32'd1 >= num) return COLD_WASH;
    return cur + 3'd1;
  endfunction

endpackage

// File: rtl/washer_panel_ctrl_if.sv
// Link between the front panel (master) and the washer program controller (slave).
interface washer_panel_ctrl_if;
  logic       power;
  logic [2:0] program_selection;
  logic       start;
  logic       doorclosed;
  logic       soap;
  logic       program_done;
  logic       soap_warning;
  logic [7:0] timer_display;

  modport master (
    output power, program_selection, start, doorclosed, soap,
    input  program_done, soap_warning, timer_display
  );

  modport slave (
    input  power, program_selection, start, doorclosed, soap,
    output program_done, soap_warning, timer_display
  );
endinterface

// File: rtl/panel_debounce.sv
// One raw panel input: 2-FF synchronizer, stable-sample counter and registered rise pulse.
module panel_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic       meta_q, sync_q, level_q, level_d, level_prev_q, press_q;
  logic [7:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = 8'd0;
    if (sync_q != level_q) begin
      if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      meta_q       <= raw;
      sync_q       <= meta_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/washer_panel_ctrl.sv
// Washer front-panel controller: input conditioning, power/program FSM, display and LEDs.
// Optional child lock is built when WASHER_CHILD_LOCK_EN is defined.
module washer_panel_ctrl
  import washer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned NUM_PROGRAMS     = DEF_NUM_PROGRAMS,
  parameter int unsigned DONE_HOLD_CYCLES = DEF_DONE_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       power_btn_raw,
  input  logic                       sel_btn_raw,
  input  logic                       start_btn_raw,
  input  logic                       door_sw_raw,
  input  logic                       soap_sw_raw,
  washer_panel_ctrl_if.master        ctrl,
  output logic                       door_lock,
  output logic                       led_done,
  output logic                       led_soap,
  output logic                       led_door_open,
  output logic                       child_lock,
  output logic [7:0]                 display,
  output logic [1:0]                 panel_state
);

  localparam int unsigned HoldW = $clog2(DONE_HOLD_CYCLES + 1);

  logic [4:0] raw, level, press;

  assign raw = {soap_sw_raw, door_sw_raw, start_btn_raw, sel_btn_raw, power_btn_raw};

  for (genvar i = 0; i < 5; i++) begin : g_db
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  logic [1:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             start_q, start_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       timer_q;
  logic             soap_warn_q;
  logic             gesture, lock;
  logic             power_p, sel_p, start_p;

`ifdef WASHER_CHILD_LOCK_EN
  logic [6:0] both_q;
  logic       lock_q;
  logic       unused_in;

  assign gesture   = level[BTN_SEL] & level[BTN_START];
  assign unused_in = ^{level[BTN_POWER], press[BTN_DOOR], press[BTN_SOAP]};

  // Counter saturates so a long hold toggles the lock only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      both_q <= 7'd0;
      lock_q <= 1'b0;
    end else begin
      if (!gesture) begin
        both_q <= 7'd0;
      end else if (both_q != 7'(CHILD_LOCK_HOLD)) begin
        both_q <= both_q + 7'd1;
      end
      if (state_d == ST_OFF && state_q != ST_OFF) begin
        lock_q <= 1'b0;
      end else if (gesture && both_q == 7'(CHILD_LOCK_HOLD - 1)) begin
        lock_q <= ~lock_q;
      end
    end
  end

  assign lock = lock_q;
`else
  logic unused_in;

  assign gesture   = 1'b0;
  assign lock      = 1'b0;
  assign unused_in = ^{level[BTN_POWER], level[BTN_SEL], level[BTN_START],
                       press[BTN_DOOR], press[BTN_SOAP]};
`endif

  assign power_p = press[BTN_POWER] & ~lock;
  assign start_p = press[BTN_START] & ~lock & ~gesture;
  assign sel_p   = press[BTN_SEL] & ~lock & ~gesture;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    hold_d  = '0;
    case (state_q)
      ST_OFF: begin
        if (power_p) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (power_p) begin
          state_d = ST_OFF;
          sel_d   = COLD_WASH;
        end else if (start_p) begin
          if (level[BTN_DOOR]) begin
            start_d = 1'b1;
            state_d = ST_RUNNING;
          end
        end else if (sel_p) begin
          sel_d = next_program(sel_q, NUM_PROGRAMS);
        end
      end
      ST_RUNNING: begin
        if (ctrl.program_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (power_p || start_p || sel_p || hold_q == HoldW'(DONE_HOLD_CYCLES - 1)) begin
          state_d = ST_SELECT;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      sel_q       <= COLD_WASH;
      start_q     <= 1'b0;
      hold_q      <= '0;
      timer_q     <= 8'd0;
      soap_warn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      hold_q      <= hold_d;
      timer_q     <= ctrl.timer_display;
      soap_warn_q <= ctrl.soap_warning;
    end
  end

  always_comb begin
    display = 8'h00;
    case (state_q)
      ST_SELECT:  display = {5'b0, sel_q};
      ST_RUNNING: display = timer_q;
      default:    display = 8'h00;
    endcase
  end

  assign ctrl.power             = (state_q != ST_OFF);
  assign ctrl.program_selection = sel_q;
  assign ctrl.start             = start_q;
  assign ctrl.doorclosed        = level[BTN_DOOR];
  assign ctrl.soap              = level[BTN_SOAP];

  assign door_lock     = (state_q == ST_RUNNING);
  assign led_done      = (state_q == ST_DONE);
  assign led_soap      = (state_q == ST_RUNNING) & soap_warn_q;
  assign led_door_open = (state_q == ST_SELECT) & ~level[BTN_DOOR];
  assign child_lock    = lock;
  assign panel_state   = state_q;

endmodule

// File: tb/tb_washer_panel_ctrl.sv
// Self-checking bench for washer_panel_ctrl: directed scenarios plus random stimulus vs a model.
module tb_washer_panel_ctrl;
  import washer_pkg::*;

  localparam int D  = DEF_DEBOUNCE_CYCLES;
  localparam int NP = DEF_NUM_PROGRAMS;
  localparam int DH = DEF_DONE_HOLD_CYCLES;
`ifdef WASHER_CHILD_LOCK_EN
  localparam bit CL_EN = 1'b1;
`else
  localparam bit CL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] raw = 5'd0;
  logic       door_lock, led_done, led_soap, led_door_open, child_lock;
  logic [7:0] display;
  logic [1:0] panel_state;

  washer_panel_ctrl_if bus ();

  washer_panel_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .power_btn_raw(raw[0]),
    .sel_btn_raw  (raw[1]),
    .start_btn_raw(raw[2]),
    .door_sw_raw  (raw[3]),
    .soap_sw_raw  (raw[4]),
    .ctrl         (bus),
    .door_lock    (door_lock),
    .led_done     (led_done),
    .led_soap     (led_soap),
    .led_door_open(led_door_open),
    .child_lock   (child_lock),
    .display      (display),
    .panel_state  (panel_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: debounce as "last D synchronized samples all disagree with the level".
  bit hist[5][$];
  bit lvl[5], rose[5], pulse[5];
  int m_state, m_sel, m_hold, m_timer, m_both;
  bit m_start, m_soapw, m_lock;

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      hist[c].delete();
      for (int i = 0; i < D + 2; i++) hist[c].push_back(1'b0);
      lvl[c] = 0; rose[c] = 0; pulse[c] = 0;
    end
    m_state = 0; m_sel = 0; m_hold = 0; m_timer = 0; m_both = 0;
    m_start = 0; m_soapw = 0; m_lock = 0;
  endtask

  task automatic model_step();
    bit pp, sp, lp, gest, all_diff;
    int ns;
    gest = CL_EN && lvl[1] && lvl[2];
    pp = pulse[0] && !m_lock;
    sp = pulse[2] && !m_lock && !gest;
    lp = pulse[1] && !m_lock && !gest;
    ns = m_state;
    m_start = 0;
    case (m_state)
      0: if (pp) ns = 1;
      1: begin
        if (pp) begin ns = 0; m_sel = 0; end
        else if (sp) begin
          if (lvl[3]) begin m_start = 1; ns = 2; end
        end else if (lp) m_sel = (m_sel + 1) % NP;
      end
      2: if (bus.program_done) begin ns = 3; m_hold = 0; end
      default: begin
        if (pp || sp || lp || m_hold == DH - 1) ns = 1;
        else m_hold++;
      end
    endcase
    if (CL_EN) begin
      if (lvl[1] && lvl[2]) begin
        m_both++;
        if (m_both == 64) m_lock = !m_lock;
      end else m_both = 0;
      if (ns == 0 && m_state != 0) m_lock = 0;
    end
    m_state = ns;
    m_timer = int'(bus.timer_display);
    m_soapw = bus.soap_warning;
    for (int c = 0; c < 5; c++) begin
      pulse[c] = rose[c];
      rose[c] = 0;
      hist[c].push_back(raw[c]);
      void'(hist[c].pop_front());
      all_diff = 1;
      for (int i = 0; i < D; i++) if (hist[c][i] == lvl[c]) all_diff = 0;
      if (all_diff) begin
        lvl[c] = !lvl[c];
        rose[c] = lvl[c];
      end
    end
  endtask

  task automatic compare_all();
    int exp_disp;
    exp_disp = (m_state == 1) ? m_sel : (m_state == 2) ? m_timer : 0;
    check("power", 32'(bus.power), 32'(m_state != 0));
    check("program_selection", 32'(bus.program_selection), 32'(m_sel));
    check("start", 32'(bus.start), 32'(m_start));
    check("doorclosed", 32'(bus.doorclosed), 32'(lvl[3]));
    check("soap", 32'(bus.soap), 32'(lvl[4]));
    check("door_lock", 32'(door_lock), 32'(m_state == 2));
    check("led_done", 32'(led_done), 32'(m_state == 3));
    check("led_soap", 32'(led_soap), 32'(m_state == 2 && m_soapw));
    check("led_door_open", 32'(led_door_open), 32'(m_state == 1 && !lvl[3]));
    check("child_lock", 32'(child_lock), 32'(m_lock));
    check("display", 32'(display), 32'(exp_disp));
    check("panel_state", 32'(panel_state), 32'(m_state));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1 compare_all();
  endtask

  task automatic hold_raw(input int ch, input bit val, input int n);
    raw[ch] = val;
    repeat (n) tick();
  endtask

  task automatic press_btn(input int ch);
    hold_raw(ch, 1'b1, 8);
    hold_raw(ch, 1'b0, 8);
  endtask

  int first_start, n_start, n;
  int exp_seq[5] = '{1, 2, 3, 4, 0};

  initial begin
    bus.program_done  = 1'b0;
    bus.soap_warning  = 1'b0;
    bus.timer_display = 8'h00;
    model_reset();
    #1;
    check("rst_state", 32'(panel_state), 32'(0));
    check("rst_outputs", 32'({bus.power, bus.start, door_lock, led_done, display}), 32'(0));
    repeat (3) tick();
    rst = 1'b0;

    // Power on.
    hold_raw(BTN_POWER, 1'b1, 20);
    check("pwr_state", 32'(panel_state), 32'(ST_SELECT));
    check("pwr_power", 32'(bus.power), 32'(1));
    check("pwr_sel", 32'(bus.program_selection), 32'(0));
    check("pwr_display", 32'(display), 32'(0));
    hold_raw(BTN_POWER, 1'b0, 10);

    // Selection wrap and a short glitch.
    for (int i = 0; i < 5; i++) begin
      press_btn(BTN_SEL);
      check("sel_seq", 32'(bus.program_selection), 32'(exp_seq[i]));
    end
    hold_raw(BTN_SEL, 1'b1, 3);
    hold_raw(BTN_SEL, 1'b0, 10);
    check("sel_glitch", 32'(bus.program_selection), 32'(0));

    // Start latency with the door closed at selection 2.
    hold_raw(BTN_DOOR, 1'b1, 10);
    press_btn(BTN_SEL);
    press_btn(BTN_SEL);
    raw[BTN_START] = 1'b1;
    first_start = 0;
    n_start = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.start === 1'b1) begin
        n_start++;
        if (first_start == 0) first_start = t;
      end
    end
    check("start_cycle", 32'(first_start), 32'(4 + D));
    check("start_width", 32'(n_start), 32'(1));
    check("run_lock", 32'(door_lock), 32'(1));
    check("run_state", 32'(panel_state), 32'(ST_RUNNING));
    check("run_sel", 32'(bus.program_selection), 32'(2));
    hold_raw(BTN_START, 1'b0, 8);

    // Running: display latency, soap LED, power ignored, done hold.
    bus.timer_display = 8'h2A;
    tick();
    check("run_display", 32'(display), 32'h2A);
    bus.soap_warning = 1'b1;
    tick();
    check("run_led_soap", 32'(led_soap), 32'(1));
    bus.soap_warning = 1'b0;
    hold_raw(BTN_POWER, 1'b1, 20);
    hold_raw(BTN_POWER, 1'b0, 8);
    check("run_pwr_ignored", 32'(panel_state), 32'(ST_RUNNING));
    bus.program_done = 1'b1;
    tick();
    bus.program_done = 1'b0;
    check("done_state", 32'(panel_state), 32'(ST_DONE));
    check("done_led", 32'(led_done), 32'(1));
    check("done_unlock", 32'(door_lock), 32'(0));
    n = 0;
    while (panel_state === ST_DONE && n < 40) begin
      tick();
      n++;
    end
    check("done_hold", 32'(n), 32'(DH));
    check("done_exit", 32'(panel_state), 32'(ST_SELECT));
    check("done_led_clr", 32'(led_done), 32'(0));

    // Door open: start refused.
    hold_raw(BTN_DOOR, 1'b0, 10);
    check("door_open_led", 32'(led_door_open), 32'(1));
    raw[BTN_START] = 1'b1;
    n_start = 0;
    repeat (8) begin
      tick();
      if (bus.start === 1'b1) n_start++;
    end
    hold_raw(BTN_START, 1'b0, 8);
    check("door_open_nostart", 32'(n_start), 32'(0));
    check("door_open_state", 32'(panel_state), 32'(ST_SELECT));

    // Asynchronous reset while running.
    hold_raw(BTN_DOOR, 1'b1, 10);
    press_btn(BTN_START);
    check("rst_pre_state", 32'(panel_state), 32'(ST_RUNNING));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_run_state", 32'(panel_state), 32'(ST_OFF));
    check("rst_run_lock", 32'(door_lock), 32'(0));
    check("rst_run_outs", 32'({bus.power, bus.doorclosed, led_done, display}), 32'(0));
    repeat (2) tick();
    rst = 1'b0;

    // Child-lock gesture (only effective when the feature is built).
    hold_raw(BTN_DOOR, 1'b0, 10);
    hold_raw(BTN_POWER, 1'b1, 8);
    hold_raw(BTN_POWER, 1'b0, 8);
    raw[BTN_SEL] = 1'b1;
    hold_raw(BTN_START, 1'b1, 80);
    check("cl_on", 32'(child_lock), 32'(CL_EN));
    raw[BTN_SEL] = 1'b0;
    hold_raw(BTN_START, 1'b0, 10);
    press_btn(BTN_POWER);
    check("cl_pwr", 32'(panel_state), CL_EN ? 32'(ST_SELECT) : 32'(ST_OFF));

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 5; c++) begin
        if ($urandom_range(0, (c == BTN_DOOR) ? 40 : 9) == 0) raw[c] = ~raw[c];
      end
      bus.program_done  = ($urandom_range(0, 29) == 0);
      bus.soap_warning  = 1'($urandom_range(0, 1));
      bus.timer_display = 8'($urandom);
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
